// File: rtl/bin_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
//
// A start strobe in idle captures a binary snapshot. WIDTH cycles later the
// packed BCD result and an overflow flag are loaded, and done pulses for one
// cycle. bcd_o and overflow_o hold their values between conversions, so a
// display scanner can sample them at any time.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset; clears all state
//   start_i     conversion request, sampled only while idle
//   bin_i       unsigned binary value, captured on the accepting edge
//   busy_o      high while a conversion is in progress
//   done_o      one-cycle pulse on the edge that updates bcd_o/overflow_o
//   bcd_o       packed BCD; digit i in bits [4i+3:4i], units in [3:0]
//   overflow_o  last converted value was >= 10^DIGITS (bcd_o holds it mod 10^DIGITS)
module bin_bcd_converter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q;
    logic [WIDTH-1:0]      shift_q;
    logic [4*DIGITS-1:0]   scratch_q;
    logic [CntW-1:0]       cnt_q;
    logic                  sticky_q;
    logic                  busy_q;
    logic                  done_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  overflow_q;

    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   scratch_shifted;
    logic                  carry_out;

    // Per-digit add-3 with no inter-digit carry; the following shift
    // moves each digit's MSB into the next digit up.
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        scratch_shifted = {adjusted[4*DIGITS-2:0], shift_q[WIDTH-1]};
        // A 1 leaving the top digit means the value no longer fits in DIGITS.
        carry_out       = adjusted[4*DIGITS-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        shift_q   <= bin_i;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        sticky_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    scratch_q <= scratch_shifted;
                    shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                    cnt_q     <= cnt_q + CntW'(1);
                    sticky_q  <= sticky_q | carry_out;
                    if (cnt_q == LastCnt) begin
                        bcd_q      <= scratch_shifted;
                        overflow_q <= sticky_q | carry_out;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bin_bcd_converter.sv
module tb_bin_bcd_converter;

    logic        clk;
    logic        rst_ni;
    logic        start;
    logic [15:0] bin;

    logic        busy, done, ovf;
    logic [19:0] bcd;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int unsigned total = 0;
    int unsigned fails = 0;

    bin_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .bin_i      (bin),
        .busy_o     (busy),
        .done_o     (done),
        .bcd_o      (bcd),
        .overflow_o (ovf)
    );

    // Four-digit instance shares the stimulus and exercises overflow.
    bin_bcd_converter #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .bin_i      (bin),
        .busy_o     (busy4),
        .done_o     (done4),
        .bcd_o      (bcd4),
        .overflow_o (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one conversion, wait (bounded) for done, check timing and result.
    task automatic run_conv(input string tag, input logic [15:0] b,
                            input logic [19:0] exp_bcd, input logic exp_ovf);
        int lat;
        bit got;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1'b1;
        end
        check({tag, " latency"}, lat, 32'd16);
        check({tag, " bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
        check({tag, " overflow"}, {31'd0, ovf}, {31'd0, exp_ovf});
        check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int ndone;
        int done_cyc;
        int nb2b;
        bit stable;
        logic [19:0] prev_bcd;

        rst_ni = 1'b0;
        start  = 1'b0;
        bin    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset bcd", {12'd0, bcd}, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Known values.
        run_conv("v0", 16'd0, 20'h00000, 1'b0);
        run_conv("v1234", 16'd1234, 20'h01234, 1'b0);
        run_conv("v9999", 16'd9999, 20'h09999, 1'b0);
        run_conv("v65535", 16'd65535, 20'h65535, 1'b0);

        // Starts while busy are ignored.
        @(negedge clk);
        bin   = 16'd42;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        ndone    = 0;
        done_cyc = -1;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (c == 2 || c == 9) begin
                start = 1'b1;
                bin   = 16'd777;
            end else begin
                start = 1'b0;
            end
        end
        check("ignored start done count", ndone, 32'd1);
        check("ignored start done cycle", done_cyc, 32'd16);
        check("ignored start bcd", {12'd0, bcd}, 32'h00042);

        // Back-to-back with start held high: accepts at 0,17,34; dones at 16,33,50.
        @(negedge clk);
        bin   = 16'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        bin      = 16'd1;
        nb2b     = 0;
        stable   = 1'b1;
        prev_bcd = bcd;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check("b2b done cycle", c, 32'(16 + 17 * nb2b));
                check("b2b bcd", {12'd0, bcd}, 32'(nb2b));
                nb2b++;
            end else if (bcd !== prev_bcd) begin
                stable = 1'b0;
            end
            prev_bcd = bcd;
            if (c % 17 == 0) bin = 16'(c / 17 + 1);
            if (c == 50) start = 1'b0;
        end
        check("b2b done count", nb2b, 32'd3);
        check("b2b bcd stable", {31'd0, stable}, 32'd1);

        // Overflow on the four-digit instance.
        run_conv("ovf12345", 16'd12345, 20'h12345, 1'b0);
        check("d4 12345 bcd", {16'd0, bcd4}, 32'h2345);
        check("d4 12345 ovf", {31'd0, ovf4}, 32'd1);
        run_conv("ovf9999", 16'd9999, 20'h09999, 1'b0);
        check("d4 9999 bcd", {16'd0, bcd4}, 32'h9999);
        check("d4 9999 ovf", {31'd0, ovf4}, 32'd0);

        // Reset mid-conversion: outputs clear before the next edge, no stale done.
        @(negedge clk);
        bin   = 16'd500;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst done", {31'd0, done}, 32'd0);
        check("async rst bcd", {12'd0, bcd}, 32'd0);
        check("async rst ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        ndone  = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("no done after reset", ndone, 32'd0);
        run_conv("v37", 16'd37, 20'h00037, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
